// File: rtl/if_id_stage.sv
// if_id_stage: PC register, next-PC selection and IF/ID pipeline register with flush accounting
module if_id_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        jump,
    input  logic        bne,
    input  logic        jr,
    input  logic [31:0] jump_target,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] IFID_pc4,
    output logic [31:0] IFID_instr,
    output logic        IFID_valid,
    output logic        IF_flush,
    output logic [15:0] flush_count
);
    typedef enum logic {BOOT, RUN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, pc4, pc4_nx, instr_nx;
    logic        valid_nx, flush_nx, redirect;
    logic [15:0] count_nx;

    assign imem_addr = pc;
    assign pc4       = pc + 32'd4;
    assign redirect  = jr | bne | jump;

    // Next-state logic: BOOT spends one edge inserting a bubble, RUN selects the PC and IF/ID load
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        pc4_nx   = IFID_pc4;
        instr_nx = IFID_instr;
        valid_nx = IFID_valid;
        flush_nx = 1'b0;
        count_nx = flush_count;
        if (state == BOOT) begin
            state_nx = RUN;
            instr_nx = 32'h0;
            valid_nx = 1'b0;
        end else begin
            pc_nx = jr    ? {jr_target[31:2], 2'b00} :
                    bne   ? {branch_target[31:2], 2'b00} :
                    jump  ? {jump_target[31:2], 2'b00} :
                    stall ? pc : pc4;
            if (redirect) begin
                instr_nx = 32'h0;
                valid_nx = 1'b0;
                flush_nx = 1'b1;
                count_nx = (flush_count == 16'hFFFF) ? flush_count : flush_count + 16'd1;
            end else if (!stall) begin
                instr_nx = imem_instr;
                pc4_nx   = pc4;
                valid_nx = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset forcing fetch back to address zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            pc          <= 32'h0;
            IFID_pc4    <= 32'h0;
            IFID_instr  <= 32'h0;
            IFID_valid  <= 1'b0;
            IF_flush    <= 1'b0;
            flush_count <= 16'h0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            IFID_pc4    <= pc4_nx;
            IFID_instr  <= instr_nx;
            IFID_valid  <= valid_nx;
            IF_flush    <= flush_nx;
            flush_count <= count_nx;
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed self-checking bench for if_id_stage
module tb_if_id_stage;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0, jump = 1'b0, bne = 1'b0, jr = 1'b0;
    logic [31:0] jump_target = 32'h0, branch_target = 32'h0, jr_target = 32'h0;
    logic [31:0] imem_instr, imem_addr, IFID_pc4, IFID_instr;
    logic        IFID_valid, IF_flush;
    logic [15:0] flush_count;
    int          checks = 0;
    int          failures = 0;

    if_id_stage dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .jump(jump), .bne(bne), .jr(jr),
        .jump_target(jump_target), .branch_target(branch_target), .jr_target(jr_target),
        .imem_instr(imem_instr), .imem_addr(imem_addr), .IFID_pc4(IFID_pc4),
        .IFID_instr(IFID_instr), .IFID_valid(IFID_valid), .IF_flush(IF_flush),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_instr = mem(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                            input logic [31:0] instr, input logic valid, input logic flush);
        chk({tag, "_addr"}, imem_addr, pc);
        chk({tag, "_pc4"}, IFID_pc4, pc4);
        chk({tag, "_instr"}, IFID_instr, instr);
        chk({tag, "_valid"}, {31'b0, IFID_valid}, {31'b0, valid});
        chk({tag, "_flush"}, {31'b0, IF_flush}, {31'b0, flush});
    endtask

    initial begin
        #12;
        chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("rst_cnt", {16'b0, flush_count}, 32'h0);
        reset_n = 1'b1;
        #2;
        chk_ifid("boot", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_ifid("run0", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_ifid("f0", 32'h4, 32'h4, mem(32'h0), 1'b1, 1'b0);
        step();
        chk_ifid("f4", 32'h8, 32'h8, mem(32'h4), 1'b1, 1'b0);
        step();
        step();
        chk_ifid("f_c", 32'h10, 32'h10, mem(32'hC), 1'b1, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("stall", 32'h10, 32'h10, mem(32'hC), 1'b1, 1'b0);
        end
        stall = 1'b0;
        step();
        chk_ifid("unstall", 32'h14, 32'h14, mem(32'h10), 1'b1, 1'b0);
        jump = 1'b1;
        jump_target = 32'h200;
        step();
        jump = 1'b0;
        chk_ifid("jump", 32'h200, 32'h14, 32'h0, 1'b0, 1'b1);
        chk("jump_cnt", {16'b0, flush_count}, 32'd1);
        step();
        chk_ifid("post_jump", 32'h204, 32'h204, mem(32'h200), 1'b1, 1'b0);
        bne = 1'b1;
        branch_target = 32'h80;
        jump = 1'b1;
        jump_target = 32'h300;
        stall = 1'b1;
        step();
        {bne, jump, stall} = 3'b000;
        chk_ifid("bne_pri", 32'h80, 32'h204, 32'h0, 1'b0, 1'b1);
        chk("bne_cnt", {16'b0, flush_count}, 32'd2);
        jr = 1'b1;
        jr_target = 32'hFFFF_FFFE;
        bne = 1'b1;
        branch_target = 32'h40;
        step();
        {jr, bne} = 2'b00;
        chk_ifid("jr_bne", 32'hFFFF_FFFC, 32'h204, 32'h0, 1'b0, 1'b1);
        chk("jr_bne_cnt", {16'b0, flush_count}, 32'd3);
        step();
        chk_ifid("wrap", 32'h0, 32'h0, mem(32'hFFFF_FFFC), 1'b1, 1'b0);
        jump = 1'b1;
        jump_target = 32'h100;
        for (int i = 0; i < 65532; i++) step();
        chk("sat_max", {16'b0, flush_count}, 32'h0000_FFFF);
        step();
        chk("sat_hold", {16'b0, flush_count}, 32'h0000_FFFF);
        chk("sat_flush", {31'b0, IF_flush}, 32'd1);
        jump = 1'b0;
        step();
        chk_ifid("sat_resume", 32'h104, 32'h104, mem(32'h100), 1'b1, 1'b0);
        jr = 1'b1;
        jr_target = 32'h500;
        #2;
        reset_n = 1'b0;
        #1;
        chk_ifid("arst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("arst_cnt", {16'b0, flush_count}, 32'h0);
        step();
        #2;
        reset_n = 1'b1;
        step();
        chk_ifid("boot_ign_jr", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("boot_ign_cnt", {16'b0, flush_count}, 32'h0);
        jr = 1'b0;
        step();
        chk_ifid("restart", 32'h4, 32'h4, mem(32'h0), 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all flops update on its rising edge
- reset_n  in  1  reset; asynchronous assert, active-low
- stall  in  1  hazard unit hold request (load-use)
- jump  in  1  ID-stage jump resolved
- bne  in  1  EX-stage bne taken
- jr  in  1  EX-stage jr resolved
- jump_target  in  32  jump destination
- branch_target  in  32  bne destination
- jr_target  in  32  jr destination (register value)
- imem_instr  in  32  instruction returned combinationally for imem_addr
- imem_addr  out  32  current PC to instruction memory
- IFID_pc4  out  32  registered PC+4 of the instruction held in IF/ID
- IFID_instr  out  32  registered instruction
- IFID_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- IF_flush  out  1  registered copy: last IF/ID load was a squash
- flush_count  out  16  saturating count of squash cycles
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-003 The block SHALL set imem_addr equal to the PC register at all times.
REQ-004 The block SHALL select the next PC by fixed priority: jr -> jr_target; else bne -> branch_target; else jump -> jump_target; else stall -> PC unchanged; else PC+4.
REQ-005 The block SHALL let a redirect (jr, bne or jump) override stall in the same cycle, because the stalled instruction is on the wrong path.
REQ-006 The block SHALL compute PC+4 modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
REQ-007 The block SHALL ignore bits [1:0] of every target and force the PC to a word-aligned value.
REQ-008 When any redirect is asserted, the block SHALL load IF/ID with a bubble at the next edge: IFID_instr=32'h0000_0000, IFID_valid=0, IFID_pc4 unchanged.
REQ-009 When stall=1 and no redirect is asserted, the block SHALL hold IFID_pc4, IFID_instr and IFID_valid unchanged.
REQ-010 Otherwise, the block SHALL load IFID_instr<=imem_instr, IFID_pc4<=PC+4 and IFID_valid<=1.
REQ-011 The block SHALL register IF_flush as 1 for exactly the cycle after each edge where a redirect was sampled, and 0 otherwise.
REQ-012 The block SHALL implement a two-state FSM:
- BOOT: entered on reset. One edge later it moves to RUN with PC unchanged and IF/ID loaded with a bubble.
- RUN: normal operation per REQ-004 to REQ-011.
- Redirect and stall inputs SHALL be ignored while the FSM is in BOOT.
REQ-013 The block SHALL increment flush_count by 1 on each edge where a redirect is sampled in RUN, and SHALL saturate it at 16'hFFFF.
REQ-014 The block SHALL produce one-cycle fetch-to-IF/ID latency: an instruction presented at PC in cycle N appears on IFID_instr after edge N+1 if not stalled or squashed.
REQ-015 The block SHALL treat simultaneous jr and bne as jr (priority per REQ-004) and count them as a single flush.

Reset
REQ-016 While reset_n=0, independent of clk, the block SHALL force:
- PC=32'h0000_0000
- IFID_pc4=0, IFID_instr=0, IFID_valid=0
- IF_flush=0, flush_count=0
- FSM=BOOT
REQ-017 Reset asserted mid-stall or mid-redirect SHALL discard that request; after release, fetch SHALL restart from 32'h0000_0000 via BOOT.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset release, no stall or redirect -> cycle 1 BOOT with IFID_valid=0. Then imem_addr 0, 4, 8 on successive cycles, and IFID_pc4=4, IFID_instr=mem[0] one cycle after PC=0 is fetched.
- stall=1 for 3 cycles at PC=0x10 -> imem_addr stays 0x10 and IF/ID is frozen; release -> 0x14 on the next edge.
- jump=1 with jump_target=0x200 -> next imem_addr=0x200, IFID_valid=0, IF_flush=1 for one cycle, flush_count=1.
- bne=1 (branch_target=0x80) together with jump=1 (jump_target=0x300) and stall=1 -> imem_addr=0x80, bubble loaded, flush_count increments by 1.
- PC=0xFFFF_FFFC, no events -> next imem_addr=0x0000_0000.
- flush_count preset near max by 65535 redirects, then one more redirect -> stays 16'hFFFF.
- reset_n pulsed low asynchronously mid-cycle during jr -> outputs zero immediately; jr is not taken after release.
